lux_avg_filter: RTL and testbench

LUX_AVG_FILTER -- requirements
Module: lux_avg_filter

---
 rtl/lux_avg_filter.sv | 146 ++++++++++++++
 tb/tb_lux_avg_filter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lux_avg_filter.sv
// Moving-average filter for lux samples over a 2^DEPTH_LOG2 window, emitting one average per sample.
// Optional spike rejection is compiled in with `define LUX_SPIKE_REJECT_EN.
module lux_avg_filter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned SPIKE_DELTA = 16'd2000,
  parameter int unsigned SPIKE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] lux_in,
  input  logic             lux_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] lux_avg,
  output logic             avg_valid,
  output logic             primed,
  output logic             overrun,
  output logic [7:0]       reject_cnt
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned SumW  = WIDTH + DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StUpdate, StEmit} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      buf_q [Depth];
  logic [SumW-1:0]       sum_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] fill_q;
  logic [WIDTH-1:0]      sample_q;
  logic [WIDTH-1:0]      lux_avg_q;
  logic                  avg_valid_q;
  logic                  primed_q;
  logic                  overrun_q;
  logic                  spike;
  logic                  accept;

`ifdef LUX_SPIKE_REJECT_EN
  logic [WIDTH-1:0] diff;
  logic [7:0]       reject_cnt_q;
  logic [7:0]       consec_q;

  always_comb begin
    diff  = (lux_in >= lux_avg_q) ? (lux_in - lux_avg_q) : (lux_avg_q - lux_in);
    // Once SPIKE_LIMIT rejections have piled up, the next outlier is taken as a real step.
    spike = primed_q && (diff > WIDTH'(SPIKE_DELTA)) && (consec_q < 8'(SPIKE_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reject_cnt_q <= '0;
      consec_q     <= '0;
    end else if (flush) begin
      reject_cnt_q <= '0;
      consec_q     <= '0;
    end else if (state_q == StIdle && lux_valid) begin
      if (spike) begin
        if (reject_cnt_q != 8'hff) reject_cnt_q <= reject_cnt_q + 8'd1;
        consec_q <= consec_q + 8'd1;
      end else begin
        consec_q <= '0;
      end
    end
  end

  assign reject_cnt = reject_cnt_q;
`else
  logic unused_spike_cfg;
  assign unused_spike_cfg = ^{SPIKE_DELTA, SPIKE_LIMIT};
  assign spike            = 1'b0;
  assign reject_cnt       = '0;
`endif

  assign accept = (state_q == StIdle) && lux_valid && !flush && !spike;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (accept) state_d = StUpdate;
        StUpdate: state_d = StEmit;
        StEmit:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) buf_q[i] <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sample_q    <= '0;
      lux_avg_q   <= '0;
      avg_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (flush) begin
      // lux_avg deliberately holds so the downstream detector keeps its last reading.
      for (int i = 0; i < Depth; i++) buf_q[i] <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      avg_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      if (lux_valid && state_q != StIdle) overrun_q <= 1'b1;
      if (accept) begin
        sample_q <= lux_in;
        if (!primed_q) begin
          fill_q <= fill_q + 1'b1;
          if (&fill_q) primed_q <= 1'b1;
        end
      end
      case (state_q)
        StUpdate: begin
          sum_q           <= sum_q + SumW'(sample_q) - SumW'(buf_q[wr_ptr_q]);
          buf_q[wr_ptr_q] <= sample_q;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        StEmit: begin
          lux_avg_q   <= sum_q[SumW-1:DEPTH_LOG2];
          avg_valid_q <= primed_q;
        end
        default: ;
      endcase
    end
  end

  assign lux_avg   = lux_avg_q;
  assign avg_valid = avg_valid_q;
  assign primed    = primed_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_lux_avg_filter.sv
// Directed self-checking bench for lux_avg_filter; spike checks follow LUX_SPIKE_REJECT_EN.
module tb_lux_avg_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] lux_in = '0;
  logic        lux_valid = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] lux_avg;
  logic        avg_valid;
  logic        primed;
  logic        overrun;
  logic [7:0]  reject_cnt;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int base;

  lux_avg_filter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lux_in    (lux_in),
    .lux_valid (lux_valid),
    .flush     (flush),
    .lux_avg   (lux_avg),
    .avg_valid (avg_valid),
    .primed    (primed),
    .overrun   (overrun),
    .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  // avg_valid level of the cycle just ended is counted at each rising edge.
  always @(posedge clk) if (avg_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;

  task automatic send(input logic [15:0] v, input int gap);
    @(negedge clk); lux_in = v; lux_valid = 1'b1;
    @(negedge clk); lux_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic prime_1000();
    do_flush();
    for (int i = 0; i < 8; i++) send(16'd1000, 3);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (lux_avg !== 16'd0 || avg_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out: lux_avg=%0d avg_valid=%b want 0/0", lux_avg, avg_valid); end
    checks++; if (primed !== 1'b0 || overrun !== 1'b0 || reject_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_flags: primed=%b overrun=%b rej=%0d want 0", primed, overrun,
                         reject_cnt); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fill();
    base = pulse_cnt;
    for (int i = 1; i <= 8; i++) begin
      send(16'd1000, 9);
      if (i == 1) begin
        checks++; if (lux_avg !== 16'd125) begin
          errors++; $display("FAIL fill_partial: lux_avg=%0d want 125", lux_avg); end
      end
      if (i == 7) begin
        checks++; if (primed !== 1'b0 || pulse_cnt !== base) begin
          errors++; $display("FAIL fill_early: primed=%b pulses=%0d want 0/%0d", primed,
                             pulse_cnt, base); end
      end
    end
    checks++; if (primed !== 1'b1) begin
      errors++; $display("FAIL fill_primed: primed=%b want 1", primed); end
    checks++; if (pulse_cnt !== base + 1 || lux_avg !== 16'd1000) begin
      errors++; $display("FAIL fill_avg: pulses=%0d lux_avg=%0d want %0d/1000", pulse_cnt,
                         lux_avg, base + 1); end
  endtask

  task automatic test_latency();
    @(negedge clk); lux_in = 16'd1800; lux_valid = 1'b1;
    @(negedge clk); lux_valid = 1'b0;
    checks++; if (avg_valid !== 1'b0) begin
      errors++; $display("FAIL lat_n0: avg_valid=%b want 0", avg_valid); end
    @(negedge clk);
    checks++; if (avg_valid !== 1'b0) begin
      errors++; $display("FAIL lat_n1: avg_valid=%b want 0", avg_valid); end
    @(negedge clk);
    checks++; if (avg_valid !== 1'b1 || lux_avg !== 16'd1100) begin
      errors++; $display("FAIL lat_n2: avg_valid=%b lux_avg=%0d want 1/1100", avg_valid, lux_avg);
    end
    @(negedge clk);
    checks++; if (avg_valid !== 1'b0) begin
      errors++; $display("FAIL lat_pulse_width: avg_valid=%b want 0", avg_valid); end
  endtask

  task automatic test_saturate();
    do_flush();
    for (int i = 1; i <= 16; i++) begin
      send(16'hffff, 3);
      if (i == 5) begin
        checks++; if (dut.wr_ptr_q !== 3'd5) begin
          errors++; $display("FAIL sat_ptr5: wr_ptr=%0d want 5", dut.wr_ptr_q); end
      end
      if (i == 8) begin
        checks++; if (dut.wr_ptr_q !== 3'd0 || primed !== 1'b1) begin
          errors++; $display("FAIL sat_wrap1: wr_ptr=%0d primed=%b want 0/1", dut.wr_ptr_q,
                             primed); end
      end
    end
    checks++; if (dut.wr_ptr_q !== 3'd0 || dut.sum_q !== 19'd524280) begin
      errors++; $display("FAIL sat_sum: wr_ptr=%0d sum=%0d want 0/524280", dut.wr_ptr_q,
                         dut.sum_q); end
    checks++; if (lux_avg !== 16'hffff) begin
      errors++; $display("FAIL sat_avg: lux_avg=%0d want 65535", lux_avg); end
  endtask

  task automatic test_back_to_back();
    do_flush();
    @(negedge clk); lux_in = 16'd800; lux_valid = 1'b1;
    @(negedge clk); lux_in = 16'd4000;
    @(negedge clk); lux_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (lux_avg !== 16'd100 || dut.sum_q !== 19'd800) begin
      errors++; $display("FAIL b2b_avg: lux_avg=%0d sum=%0d want 100/800", lux_avg, dut.sum_q); end
    repeat (5) @(negedge clk);
    checks++; if (overrun !== 1'b1) begin
      errors++; $display("FAIL b2b_overrun: overrun=%b want 1", overrun); end
    do_flush();
    checks++; if (overrun !== 1'b0 || lux_avg !== 16'd100) begin
      errors++; $display("FAIL b2b_flush: overrun=%b lux_avg=%0d want 0/100", overrun, lux_avg); end
  endtask

  task automatic test_flush();
    prime_1000();
    base = pulse_cnt;
    @(negedge clk); flush = 1'b1; lux_valid = 1'b1; lux_in = 16'd5000;
    @(negedge clk); flush = 1'b0; lux_valid = 1'b0;
    checks++; if (primed !== 1'b0 || overrun !== 1'b0 || dut.sum_q !== 19'd0 ||
                  dut.wr_ptr_q !== 3'd0) begin
      errors++; $display("FAIL flush_clear: primed=%b overrun=%b sum=%0d ptr=%0d want 0", primed,
                         overrun, dut.sum_q, dut.wr_ptr_q); end
    repeat (4) @(negedge clk);
    checks++; if (dut.sum_q !== 19'd0 || pulse_cnt !== base || lux_avg !== 16'd1000) begin
      errors++; $display("FAIL flush_ignore: sum=%0d pulses=%0d lux_avg=%0d want 0/%0d/1000",
                         dut.sum_q, pulse_cnt, base, lux_avg); end
    prime_1000();
    base = pulse_cnt;
    send(16'd1800, 0);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (pulse_cnt !== base || lux_avg !== 16'd1000 || dut.sum_q !== 19'd0) begin
      errors++; $display("FAIL flush_abort: pulses=%0d lux_avg=%0d sum=%0d want %0d/1000/0",
                         pulse_cnt, lux_avg, dut.sum_q, base); end
  endtask

  task automatic test_reset_midop();
    prime_1000();
    base = pulse_cnt;
    send(16'd1800, 0);
    rst_n = 1'b0;
    #1;
    checks++; if (lux_avg !== 16'd0 || primed !== 1'b0) begin
      errors++; $display("FAIL rst_async: lux_avg=%0d primed=%b want 0/0", lux_avg, primed); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dut.sum_q !== 19'd0 || pulse_cnt !== base) begin
      errors++; $display("FAIL rst_discard: sum=%0d pulses=%0d want 0/%0d", dut.sum_q, pulse_cnt,
                         base); end
    send(16'd2400, 3);
    checks++; if (lux_avg !== 16'd300) begin
      errors++; $display("FAIL rst_first: lux_avg=%0d want 300", lux_avg); end
  endtask

`ifdef LUX_SPIKE_REJECT_EN
  task automatic test_spike();
    prime_1000();
    base = pulse_cnt;
    for (int k = 0; k < 3; k++) send(16'd9000, 4);
    checks++; if (reject_cnt !== 8'd3 || lux_avg !== 16'd1000 || pulse_cnt !== base) begin
      errors++; $display("FAIL spike_reject: rej=%0d lux_avg=%0d pulses=%0d want 3/1000/%0d",
                         reject_cnt, lux_avg, pulse_cnt, base); end
    send(16'd9000, 4);
    checks++; if (lux_avg !== 16'd2000 || pulse_cnt !== base + 1) begin
      errors++; $display("FAIL spike_accept: lux_avg=%0d pulses=%0d want 2000/%0d", lux_avg,
                         pulse_cnt, base + 1); end
    send(16'd9000, 4);
    checks++; if (reject_cnt !== 8'd4 || lux_avg !== 16'd2000) begin
      errors++; $display("FAIL spike_fifth: rej=%0d lux_avg=%0d want 4/2000", reject_cnt, lux_avg);
    end
  endtask
`else
  task automatic test_spike();
    prime_1000();
    send(16'd9000, 4);
    checks++; if (lux_avg !== 16'd2000 || reject_cnt !== 8'd0) begin
      errors++; $display("FAIL spike_off: lux_avg=%0d rej=%0d want 2000/0", lux_avg, reject_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_latency();
    test_saturate();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    test_spike();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
